mmio_uart_tx: RTL and testbench

//  Memory-mapped serial output device on the 32-bit MIPS data bus, alongside sram0 in devices0.

---
 rtl/mmio_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped serial transmitter that sits on the 32-bit CPU data bus.
//   A store to TX_ADDR enqueues writedata[7:0] into a small FIFO. The FIFO
//   is drained as 8N1 frames (start, 8 data bits LSB first, stop) on txd.
//   A status word can be loaded from STAT_ADDR. A store to STAT_ADDR with
//   writedata[9] set clears the sticky overflow flag.
//
// Ports
//   clk        in   1      system clock, all state on posedge
//   reset_     in   1      asynchronous active-low reset
//   memwrite   in   1      CPU store strobe
//   memread    in   1      CPU load strobe
//   adr        in   WIDTH  CPU byte address
//   writedata  in   WIDTH  CPU store data
//   sel        out  1      access hits TX_ADDR or STAT_ADDR (combinational)
//   rdata      out  WIDTH  status word on a STAT_ADDR load, else 0
//   txd        out  1      registered serial line, idle high
//   busy       out  1      frame in progress or FIFO non-empty
//
// Status word: [3:0] count, [4] full, [5] empty, [8] busy, [9] ovf.
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] TX_ADDR   = 32'h0000_0100,
    parameter logic [WIDTH-1:0] STAT_ADDR = 32'h0000_0104,
    parameter int               DEPTH     = 8,
    parameter int               AW        = 3,
    parameter int               BAUD_DIV  = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic             sel,
    output logic [WIDTH-1:0] rdata,
    output logic             txd,
    output logic             busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO state
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    // Transmitter state
    logic [1:0]    r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic          r_txd;

    logic             w_hit_tx;
    logic             w_hit_stat;
    logic             w_push_req;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_clr;
    logic             w_baud_end;
    logic             w_busy;
    logic [WIDTH-1:0] w_status;

    // Only byte 0 and bit 9 of writedata carry meaning; the rest is folded
    // into a deliberately unused signal.
    logic w_unused_wd;
    assign w_unused_wd = &{1'b0, writedata[WIDTH-1:10], writedata[8]};

    assign w_hit_tx   = (adr == TX_ADDR);
    assign w_hit_stat = (adr == STAT_ADDR);
    assign w_push_req = memwrite && w_hit_tx;
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Pop decision uses the registered count, so a byte pushed into an
    // empty FIFO is never popped on the same edge.
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    // A pop on the same edge frees a slot, so a store to a full FIFO is
    // still accepted when the transmitter takes the head.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_clr  = memwrite && w_hit_stat && writedata[9];
    assign w_baud_end = (r_baud_cnt == CW'(BAUD_DIV - 1));
    assign w_busy     = (r_state != S_IDLE) || !w_empty;

    // NOTE: every variable written in always_comb gets a default first,
    //       otherwise an unassigned path infers a latch.
    always_comb begin
        w_status       = '0;
        w_status[AW:0] = r_count;
        w_status[4]    = w_full;
        w_status[5]    = w_empty;
        w_status[8]    = w_busy;
        w_status[9]    = r_ovf;
    end

    assign sel   = (memread || memwrite) && (w_hit_tx || w_hit_stat);
    assign rdata = (memread && w_hit_stat) ? w_status : '0;
    assign txd   = r_txd;
    assign busy  = w_busy;

    // NOTE: the FIFO storage has no reset; the empty flag guards every read,
    //       so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            // Clear and overflow target different addresses, so they never
            // coincide on one edge.
            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shreg    <= r_mem[r_rd_ptr];
                        r_baud_cnt <= '0;
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
                        r_txd      <= r_shreg[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_shreg    <= {1'b0, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // Next bit is the one that lands in [0] after the shift.
                            r_txd     <= r_shreg[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    r_txd <= 1'b1;
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Self-checking bench for mmio_uart_tx with BAUD_DIV=4, DEPTH=8.
//   Bus decode is checked from a vector table; multi-cycle behaviour
//   (frame timing, reset mid-frame, overflow, push on pop edge) is checked
//   with hand-written sequences. A serial receiver model collects frames
//   from txd and compares them to the bytes the bench expects to be sent.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam int          BD   = 4;
    localparam logic [31:0] TX   = 32'h0000_0100;
    localparam logic [31:0] STAT = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset_;
    logic        memwrite;
    logic        memread;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    mmio_uart_tx #(
        .WIDTH    (32),
        .TX_ADDR  (TX),
        .STAT_ADDR(STAT),
        .DEPTH    (8),
        .AW       (3),
        .BAUD_DIV (BD)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .memwrite (memwrite),
        .memread  (memread),
        .adr      (adr),
        .writedata(writedata),
        .sel      (sel),
        .rdata    (rdata),
        .txd      (txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- serial receiver model ----------------
    // Sample index 0 is the first falling-edge sample with txd low; data
    // bit i is taken mid-bit at index 6+4*i, stop bit at index 38.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_sh     = '0;
    int         frame_err  = 0;

    always @(negedge clk) begin
        if (!reset_) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (txd == 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % BD) == 2) begin
                mon_sh <= {txd, mon_sh[7:1]};
            end
            if (mon_cnt == 38) begin
                if (txd !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(mon_sh);
            end
            if (mon_cnt == 39) mon_active <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; combinational read, no clock edge consumed.
    task automatic read_status(output logic [31:0] v, output logic s);
        memread = 1'b1;
        adr     = STAT;
        #1;
        v       = rdata;
        s       = sel;
        memread = 1'b0;
        adr     = '0;
    endtask

    // Called at a falling edge; the store takes effect on the next posedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, busy}, 32'h0);
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] st;
    logic        s;
    logic [7:0]  b55;
    int          t0;
    logic        bad;

    initial begin
        // Idle, empty FIFO: status word is 32'h20.
        vecs[0] = '{1'b1, 1'b0, STAT,          32'h0,   1'b1, 32'h20};
        vecs[1] = '{1'b1, 1'b0, TX,            32'h0,   1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, TX,            32'h41,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, STAT,          32'h0,   1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, STAT,          32'h0,   1'b1, 32'h20};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,   1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, STAT,          32'h0,   1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,   1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0105, 32'h0,   1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0108, 32'h55,  1'b0, 32'h0};

        reset_    = 1'b0;
        memwrite  = 1'b0;
        memread   = 1'b0;
        adr       = '0;
        writedata = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        read_status(st, s);
        check("rst_status", st, 32'h20);
        reset_ = 1'b1;
        @(negedge clk);
        read_status(st, s);
        check("post_rst_status", st, 32'h20);

        // ---- bus decode table (inputs withdrawn before the next edge) ----
        for (int i = 0; i < 10; i++) begin
            memread   = vecs[i].rd;
            memwrite  = vecs[i].wr;
            adr       = vecs[i].a;
            writedata = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            memread   = 1'b0;
            memwrite  = 1'b0;
            adr       = '0;
            writedata = '0;
            @(negedge clk);
        end
        read_status(st, s);
        check("table_no_side_effect", st, 32'h20);

        // ---- single frame, exact bit timing ----
        b55 = 8'h55;
        store(TX, 32'hABCD_0055);
        exp_q.push_back(8'h55);
        check("f1_busy_after_push", {31'b0, busy}, 32'h1);
        check("f1_txd_idle_edgeN", {31'b0, txd}, 32'h1);
        read_status(st, s);
        check("f1_status_count1", st, 32'h101);
        for (int k = 0; k < 10 * BD; k++) begin
            logic exp_b;
            @(negedge clk);
            if (k < BD)            exp_b = 1'b0;
            else if (k < 9 * BD)   exp_b = b55[(k - BD) / BD];
            else                   exp_b = 1'b1;
            check($sformatf("f1_txd_k%0d", k), {31'b0, txd}, {31'b0, exp_b});
        end
        @(negedge clk);
        check("f1_busy_after_41", {31'b0, busy}, 32'h0);
        read_status(st, s);
        check("f1_status_idle", st, 32'h20);

        // ---- reset asserted mid-frame ----
        store(TX, 32'h0000_00F0);
        @(negedge clk);
        @(negedge clk);
        check("rmid_txd_low_pre", {31'b0, txd}, 32'h0);
        reset_ = 1'b0;
        #1;
        check("rmid_txd_forced", {31'b0, txd}, 32'h1);
        check("rmid_busy", {31'b0, busy}, 32'h0);
        read_status(st, s);
        check("rmid_status", st, 32'h20);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("rmid_stays_idle", {31'b0, bad}, 32'h0);

        // ---- fill while frame 1 is on the wire, overflow ----
        store(TX, 32'h0000_0001);
        t0 = edge_cnt;
        exp_q.push_back(8'h01);
        for (int k = 2; k <= 9; k++) begin
            store(TX, 32'hFFFF_FF00 | k);
            exp_q.push_back(8'(k));
        end
        read_status(st, s);
        check("fill_status_full", st, 32'h118);
        store(TX, 32'h0000_00EE);
        read_status(st, s);
        check("ovf_status", st, 32'h318);

        // ---- ovf clear and ignored address ----
        store(STAT, 32'h0000_0200);
        read_status(st, s);
        check("ovf_clear_status", st, 32'h118);
        memwrite  = 1'b1;
        adr       = 32'h0000_0108;
        writedata = 32'h0000_0277;
        #1;
        check("adr108_sel", {31'b0, sel}, 32'h0);
        @(negedge clk);
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
        read_status(st, s);
        check("adr108_no_effect", st, 32'h118);

        // ---- store on the edge the FSM pops a full FIFO ----
        // Frame 1 popped on edge t0+1 and returns to IDLE on edge t0+41;
        // frame 2 is popped on edge t0+42.
        while (edge_cnt < t0 + 41) @(negedge clk);
        check("popedge_txd_idle", {31'b0, txd}, 32'h1);
        store(TX, 32'h0000_000A);
        exp_q.push_back(8'h0A);
        check("popedge_txd_start", {31'b0, txd}, 32'h0);
        read_status(st, s);
        check("popedge_status", st, 32'h118);

        wait_idle(2000, "drain_fill_timeout");

        // ---- load status with three queued and a frame active ----
        store(TX, 32'h0000_00A5);
        store(TX, 32'h0000_003C);
        store(TX, 32'h0000_00F0);
        store(TX, 32'h0000_000F);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        read_status(st, s);
        check("q3_rdata", st, 32'h103);
        check("q3_sel", {31'b0, s}, 32'h1);
        memread = 1'b1;
        adr     = 32'h0;
        #1;
        check("load0_rdata", rdata, 32'h0);
        check("load0_sel", {31'b0, sel}, 32'h0);
        memread = 1'b0;

        wait_idle(1000, "drain_q3_timeout");
        repeat (4) @(negedge clk);

        // ---- serial stream compared to expected byte order ----
        check("rx_frame_count", rx_q.size(), exp_q.size());
        check("rx_framing_errors", frame_err, 0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog: the sequences above need roughly 1.5k cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
